stack_engine: RTL and testbench

//  Parametrised stack unit replacing the ad-hoc SP register/decSP logic of the core pipeline.

---
 rtl/stack_engine.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_stack_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// Stack unit: owns SP and occupancy, sequences multi-word PUSH/POP/CALL/RET/INT/RTI
// transfers on the data-memory port, and flags refused operations as overflow/underflow.
module stack_engine #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 11,
  parameter int PC_W        = 32,
  parameter int FLAGS_W     = 4,
  parameter int STACK_TOP   = (1 << ADDR_W) - 1,
  parameter int STACK_FLOOR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [2:0]          req_op,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   push_data,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [FLAGS_W-1:0]  flags_in,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_rd,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                pop_valid,
  output logic [DATA_W-1:0]   pop_data,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_out,
  output logic                flags_load,
  output logic [FLAGS_W-1:0]  flags_out,
  output logic [ADDR_W-1:0]   sp,
  output logic [ADDR_W:0]     depth,
  output logic                overflow,
  output logic                underflow
);

  localparam int PCW     = PC_W / DATA_W;
  localparam int NW      = PCW + 1;
  localparam int CW      = $clog2(NW + 1);
  localparam int DEPTH_W = ADDR_W + 1;
  localparam int CAP     = STACK_TOP - STACK_FLOOR + 1;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                        state_q, state_d;
  logic [2:0]                    op_q, op_d;
  logic [CW-1:0]                 n_q, n_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NW-1:0][DATA_W-1:0]     wbuf_q, wbuf_d;
  logic [NW-1:0][DATA_W-1:0]     rbuf_q, rbuf_d;
  logic [ADDR_W-1:0]             sp_q, sp_d;
  logic [DEPTH_W-1:0]            depth_q, depth_d;
  logic                          req_ready_q, req_ready_d;
  logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
  logic                          mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
  logic                          mem_rd_q, mem_rd_d;
  logic                          pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0]             pop_data_q, pop_data_d;
  logic                          pc_load_q, pc_load_d;
  logic [PC_W-1:0]               pc_out_q, pc_out_d;
  logic                          flags_load_q, flags_load_d;
  logic [FLAGS_W-1:0]            flags_out_q, flags_out_d;
  logic                          overflow_q, overflow_d;
  logic                          underflow_q, underflow_d;

  logic [DEPTH_W-1:0]            req_n;
  logic                          req_is_push;
  logic                          req_is_pop;
  logic                          push_fits;
  logic                          last_word;

  // Word count and capacity check for the request currently presented.
  always_comb begin
    req_n       = '0;
    req_is_push = 1'b0;
    req_is_pop  = 1'b0;
    case (req_op)
      OP_PUSH: begin req_n = DEPTH_W'(1);       req_is_push = 1'b1; end
      OP_POP:  begin req_n = DEPTH_W'(1);       req_is_pop  = 1'b1; end
      OP_CALL: begin req_n = DEPTH_W'(PCW);     req_is_push = 1'b1; end
      OP_RET:  begin req_n = DEPTH_W'(PCW);     req_is_pop  = 1'b1; end
      OP_INT:  begin req_n = DEPTH_W'(PCW + 1); req_is_push = 1'b1; end
      OP_RTI:  begin req_n = DEPTH_W'(PCW + 1); req_is_pop  = 1'b1; end
      default: req_n = '0;
    endcase
    push_fits = ({1'b0, depth_q} + {1'b0, req_n}) <= (DEPTH_W + 1)'(CAP);
    last_word = (cnt_q == (n_q - CNT_ONE));
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    wbuf_d       = wbuf_q;
    rbuf_d       = rbuf_q;
    sp_d         = sp_q;
    depth_d      = depth_q;
    pop_valid_d  = 1'b0;
    pc_load_d    = 1'b0;
    flags_load_d = 1'b0;
    pop_data_d   = pop_data_q;
    pc_out_d     = pc_out_q;
    flags_out_d  = flags_out_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          n_d   = CW'(req_n);
          cnt_d = '0;
          if (req_is_push) begin
            if (push_fits) begin
              state_d = S_WRITE;
              wbuf_d  = '0;
              // Write order is the reverse of the read order: high PC word lands deepest.
              if (req_op == OP_PUSH) begin
                wbuf_d[0] = push_data;
              end else if (req_op == OP_CALL) begin
                for (int k = 0; k < PCW; k++) begin
                  wbuf_d[k] = pc_in[(PCW - 1 - k) * DATA_W +: DATA_W];
                end
              end else begin
                wbuf_d[0] = DATA_W'(flags_in);
                for (int k = 0; k < PCW; k++) begin
                  wbuf_d[k + 1] = pc_in[(PCW - 1 - k) * DATA_W +: DATA_W];
                end
              end
            end else begin
              state_d    = S_ERR;
              overflow_d = 1'b1;
            end
          end else if (req_is_pop) begin
            if (depth_q >= req_n) begin
              state_d = S_READ;
            end else begin
              state_d     = S_ERR;
              underflow_d = 1'b1;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_WRITE: begin
        sp_d    = sp_q - ADDR_W'(1);
        depth_d = depth_q + DEPTH_W'(1);
        if (last_word) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_READ: begin
        sp_d    = sp_q + ADDR_W'(1);
        depth_d = depth_q - DEPTH_W'(1);
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        rbuf_d[cnt_q] = mem_rdata;
        if (last_word) begin
          state_d = S_DONE;
          if (op_q == OP_POP) begin
            pop_valid_d = 1'b1;
            pop_data_d  = mem_rdata;
          end else begin
            pc_load_d = 1'b1;
            for (int j = 0; j < PCW; j++) begin
              pc_out_d[j * DATA_W +: DATA_W] = rbuf_d[j];
            end
            if (op_q == OP_RTI) begin
              flags_load_d = 1'b1;
              flags_out_d  = rbuf_d[PCW][FLAGS_W-1:0];
            end
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_READ;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Memory strobes are registered, so they are decoded from the next state and next SP.
    req_ready_d = (state_d == S_IDLE);
    mem_wr_d    = (state_d == S_WRITE);
    mem_rd_d    = (state_d == S_READ);
    mem_wdata_d = mem_wr_d ? wbuf_d[cnt_d] : '0;
    if (mem_wr_d) begin
      mem_addr_d = sp_d;
    end else if (mem_rd_d) begin
      mem_addr_d = sp_d + ADDR_W'(1);
    end else begin
      mem_addr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      wbuf_q       <= '0;
      rbuf_q       <= '0;
      sp_q         <= ADDR_W'(STACK_TOP);
      depth_q      <= '0;
      req_ready_q  <= 1'b1;
      mem_addr_q   <= '0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      pop_valid_q  <= 1'b0;
      pop_data_q   <= '0;
      pc_load_q    <= 1'b0;
      pc_out_q     <= '0;
      flags_load_q <= 1'b0;
      flags_out_q  <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      wbuf_q       <= wbuf_d;
      rbuf_q       <= rbuf_d;
      sp_q         <= sp_d;
      depth_q      <= depth_d;
      req_ready_q  <= req_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_q     <= mem_wr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      pop_valid_q  <= pop_valid_d;
      pop_data_q   <= pop_data_d;
      pc_load_q    <= pc_load_d;
      pc_out_q     <= pc_out_d;
      flags_load_q <= flags_load_d;
      flags_out_q  <= flags_out_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rd     = mem_rd_q;
  assign pop_valid  = pop_valid_q;
  assign pop_data   = pop_data_q;
  assign pc_load    = pc_load_q;
  assign pc_out     = pc_out_q;
  assign flags_load = flags_load_q;
  assign flags_out  = flags_out_q;
  assign sp         = sp_q;
  assign depth      = depth_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: a full-size stack (a) and a two-word stack (b, floor 2046),
// each with its own word memory returning read data one cycle after the strobe.
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] push_data = 16'h0;
  logic [31:0] pc_in = 32'h0;
  logic [3:0]  flags_in = 4'h0;

  logic        req_ready_a, mem_wr_a, mem_rd_a, pop_valid_a, pc_load_a, flags_load_a, overflow_a, underflow_a;
  logic [10:0] mem_addr_a, sp_a;
  logic [11:0] depth_a;
  logic [15:0] mem_wdata_a, mem_rdata_a, pop_data_a;
  logic [31:0] pc_out_a;
  logic [3:0]  flags_out_a;

  logic        req_ready_b, mem_wr_b, mem_rd_b, pop_valid_b, pc_load_b, flags_load_b, overflow_b, underflow_b;
  logic [10:0] mem_addr_b, sp_b;
  logic [11:0] depth_b;
  logic [15:0] mem_wdata_b, mem_rdata_b, pop_data_b;
  logic [31:0] pc_out_b;
  logic [3:0]  flags_out_b;

  logic [15:0] mem_a [2048];
  logic [15:0] mem_b [2048];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stack_engine dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_op(req_op), .req_ready(req_ready_a),
    .push_data(push_data), .pc_in(pc_in), .flags_in(flags_in),
    .mem_addr(mem_addr_a), .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a), .mem_rd(mem_rd_a),
    .mem_rdata(mem_rdata_a), .pop_valid(pop_valid_a), .pop_data(pop_data_a),
    .pc_load(pc_load_a), .pc_out(pc_out_a), .flags_load(flags_load_a), .flags_out(flags_out_a),
    .sp(sp_a), .depth(depth_a), .overflow(overflow_a), .underflow(underflow_a)
  );

  stack_engine #(.STACK_FLOOR(2046)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_op(req_op), .req_ready(req_ready_b),
    .push_data(push_data), .pc_in(pc_in), .flags_in(flags_in),
    .mem_addr(mem_addr_b), .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b), .mem_rd(mem_rd_b),
    .mem_rdata(mem_rdata_b), .pop_valid(pop_valid_b), .pop_data(pop_data_b),
    .pc_load(pc_load_b), .pc_out(pc_out_b), .flags_load(flags_load_b), .flags_out(flags_out_b),
    .sp(sp_b), .depth(depth_b), .overflow(overflow_b), .underflow(underflow_b)
  );

  always @(posedge clk) begin
    if (mem_wr_a) mem_a[mem_addr_a] <= mem_wdata_a;
    if (mem_rd_a) mem_rdata_a <= mem_a[mem_addr_a];
    if (mem_wr_b) mem_b[mem_addr_b] <= mem_wdata_b;
    if (mem_rd_b) mem_rdata_b <= mem_b[mem_addr_b];
  end

  typedef struct {
    bit          inst_b;
    logic [2:0]  op;
    logic [15:0] din;
    logic [31:0] pc;
    logic [3:0]  fl;
    int          e_ready;
    int          e_pulse;
    logic [2:0]  e_kinds;
    logic [31:0] e_data;
    logic [3:0]  e_flags;
    logic [10:0] e_sp;
    logic [11:0] e_depth;
    int          e_wr;
    int          e_rd;
    logic [10:0] e_addr0;
    logic [15:0] e_wdata0;
    bit          e_ovf;
    bit          e_unf;
  } vec_t;

  vec_t vecs[$];

  int          rec_ready, rec_pulse, rec_pcycles, rec_pulses, rec_wr, rec_rd, rec_both;
  logic [2:0]  rec_kinds;
  logic [10:0] rec_addr0;
  logic [15:0] rec_wdata0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request and follows it, one sample per cycle, until req_ready returns.
  task automatic applyStimulus(input bit use_b, input logic [2:0] op, input logic [15:0] din,
                               input logic [31:0] pc, input logic [3:0] fl);
    int   cyc;
    bit   done;
    logic s_rdy, s_wr, s_rd, s_pv, s_pl, s_fl;
    logic [10:0] s_addr;
    logic [15:0] s_wd;
    @(negedge clk);
    req_op = op; push_data = din; pc_in = pc; flags_in = fl;
    if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    rec_ready = -1; rec_pulse = 0; rec_pcycles = 0; rec_pulses = 0;
    rec_wr = 0; rec_rd = 0; rec_both = 0; rec_kinds = 3'b000; rec_addr0 = '0; rec_wdata0 = '0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid_a = 1'b0; req_valid_b = 1'b0;
      req_op = 3'd4; push_data = 16'hDEAD; pc_in = 32'hFFFF_FFFF; flags_in = 4'hF;
      s_rdy  = use_b ? req_ready_b : req_ready_a;
      s_wr   = use_b ? mem_wr_b : mem_wr_a;
      s_rd   = use_b ? mem_rd_b : mem_rd_a;
      s_pv   = use_b ? pop_valid_b : pop_valid_a;
      s_pl   = use_b ? pc_load_b : pc_load_a;
      s_fl   = use_b ? flags_load_b : flags_load_a;
      s_addr = use_b ? mem_addr_b : mem_addr_a;
      s_wd   = use_b ? mem_wdata_b : mem_wdata_a;
      if ((s_wr || s_rd) && (rec_wr + rec_rd == 0)) begin
        rec_addr0  = s_addr;
        rec_wdata0 = s_wr ? s_wd : 16'h0;
      end
      if (s_wr) rec_wr++;
      if (s_rd) rec_rd++;
      if (s_wr && s_rd) rec_both++;
      if (s_pv || s_pl || s_fl) begin
        rec_pcycles++;
        rec_pulse = cyc;
      end
      rec_kinds  = rec_kinds | {s_pv, s_pl, s_fl};
      rec_pulses = rec_pulses + int'(s_pv) + int'(s_pl) + int'(s_fl);
      if (s_rdy) begin
        done = 1'b1;
        rec_ready = cyc;
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // inst, op, din, pc, fl | ready, pulse, kinds{pv,pl,fl}, data, flags, sp, depth, wr, rd, addr0, wdata0, ovf, unf
    vecs.push_back('{0, 3'd0, 16'hABCD, 32'h0, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2046, 12'd1, 1, 0, 11'd2047, 16'hABCD, 0, 0});
    vecs.push_back('{0, 3'd1, 16'h0, 32'h0, 4'h0, 4, 3, 3'b100, 32'hABCD, 4'h0, 11'd2047, 12'd0, 0, 1, 11'd2047, 16'h0, 0, 0});
    vecs.push_back('{0, 3'd2, 16'h0, 32'h0001_0234, 4'h0, 3, 0, 3'b000, 32'h0, 4'h0, 11'd2045, 12'd2, 2, 0, 11'd2047, 16'h0001, 0, 0});
    vecs.push_back('{0, 3'd3, 16'h0, 32'h0, 4'h0, 6, 5, 3'b010, 32'h0001_0234, 4'h0, 11'd2047, 12'd0, 0, 2, 11'd2046, 16'h0, 0, 0});
    vecs.push_back('{0, 3'd4, 16'h0, 32'h0000_0050, 4'hA, 4, 0, 3'b000, 32'h0, 4'h0, 11'd2044, 12'd3, 3, 0, 11'd2047, 16'h000A, 0, 0});
    vecs.push_back('{0, 3'd5, 16'h0, 32'h0, 4'h0, 8, 7, 3'b011, 32'h0000_0050, 4'hA, 11'd2047, 12'd0, 0, 3, 11'd2045, 16'h0, 0, 0});
    vecs.push_back('{0, 3'd6, 16'h0, 32'h0, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2047, 12'd0, 0, 0, 11'd0, 16'h0, 0, 0});
    vecs.push_back('{0, 3'd0, 16'h1234, 32'h0, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2046, 12'd1, 1, 0, 11'd2047, 16'h1234, 0, 0});
    vecs.push_back('{0, 3'd0, 16'hFFFF, 32'h0, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2045, 12'd2, 1, 0, 11'd2046, 16'hFFFF, 0, 0});
    vecs.push_back('{0, 3'd1, 16'h0, 32'h0, 4'h0, 4, 3, 3'b100, 32'hFFFF, 4'h0, 11'd2046, 12'd1, 0, 1, 11'd2046, 16'h0, 0, 0});
    vecs.push_back('{0, 3'd1, 16'h0, 32'h0, 4'h0, 4, 3, 3'b100, 32'h1234, 4'h0, 11'd2047, 12'd0, 0, 1, 11'd2047, 16'h0, 0, 0});
    vecs.push_back('{0, 3'd2, 16'h0, 32'hDEAD_BEEF, 4'h0, 3, 0, 3'b000, 32'h0, 4'h0, 11'd2045, 12'd2, 2, 0, 11'd2047, 16'hDEAD, 0, 0});
    vecs.push_back('{0, 3'd3, 16'h0, 32'h0, 4'h0, 6, 5, 3'b010, 32'hDEAD_BEEF, 4'h0, 11'd2047, 12'd0, 0, 2, 11'd2046, 16'h0, 0, 0});
    vecs.push_back('{1, 3'd0, 16'h1111, 32'h0, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2046, 12'd1, 1, 0, 11'd2047, 16'h1111, 0, 0});
    vecs.push_back('{1, 3'd0, 16'h2222, 32'h0, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2045, 12'd2, 1, 0, 11'd2046, 16'h2222, 0, 0});
    vecs.push_back('{1, 3'd2, 16'h0, 32'h1234_5678, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2045, 12'd2, 0, 0, 11'd0, 16'h0, 1, 0});
    vecs.push_back('{1, 3'd1, 16'h0, 32'h0, 4'h0, 4, 3, 3'b100, 32'h2222, 4'h0, 11'd2046, 12'd1, 0, 1, 11'd2046, 16'h0, 1, 0});
    vecs.push_back('{1, 3'd1, 16'h0, 32'h0, 4'h0, 4, 3, 3'b100, 32'h1111, 4'h0, 11'd2047, 12'd0, 0, 1, 11'd2047, 16'h0, 1, 0});
    vecs.push_back('{1, 3'd1, 16'h0, 32'h0, 4'h0, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2047, 12'd0, 0, 0, 11'd0, 16'h0, 1, 1});
    vecs.push_back('{1, 3'd4, 16'h0, 32'h0000_0001, 4'h3, 2, 0, 3'b000, 32'h0, 4'h0, 11'd2047, 12'd0, 0, 0, 11'd0, 16'h0, 1, 1});

    // Reset state of both instances while reset is held.
    repeat (3) @(negedge clk);
    checkOutput("reset sp_a", 32'(sp_a), 32'd2047);
    checkOutput("reset depth_a", 32'(depth_a), 32'd0);
    checkOutput("reset ready_a", 32'(req_ready_a), 32'd1);
    checkOutput("reset strobes_a", 32'({mem_wr_a, mem_rd_a, pop_valid_a, pc_load_a, flags_load_a}), 32'd0);
    checkOutput("reset sticky_a", 32'({overflow_a, underflow_a}), 32'd0);
    checkOutput("reset mem_addr_a", 32'(mem_addr_a), 32'd0);
    checkOutput("reset sp_b", 32'(sp_b), 32'd2047);
    checkOutput("reset depth_b", 32'(depth_b), 32'd0);
    checkOutput("reset ready_b", 32'(req_ready_b), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset ready_a", 32'(req_ready_a), 32'd1);

    foreach (vecs[i]) begin
      vec_t v;
      logic [31:0] act_data;
      logic [3:0]  act_flags;
      v = vecs[i];
      applyStimulus(v.inst_b, v.op, v.din, v.pc, v.fl);
      if (v.e_kinds[2]) act_data = v.inst_b ? {16'h0, pop_data_b} : {16'h0, pop_data_a};
      else              act_data = v.inst_b ? pc_out_b : pc_out_a;
      act_flags = v.inst_b ? flags_out_b : flags_out_a;
      checkOutput($sformatf("v%0d ready cycle", i), 32'(rec_ready), 32'(v.e_ready));
      checkOutput($sformatf("v%0d pulse cycle", i), 32'(rec_pulse), 32'(v.e_pulse));
      checkOutput($sformatf("v%0d pulse kinds", i), 32'(rec_kinds), 32'(v.e_kinds));
      checkOutput($sformatf("v%0d pulse count", i), 32'(rec_pulses), 32'($countones(v.e_kinds)));
      checkOutput($sformatf("v%0d pulse cycles", i), 32'(rec_pcycles), (v.e_kinds != 3'b000) ? 32'd1 : 32'd0);
      if (v.e_kinds != 3'b000) checkOutput($sformatf("v%0d data", i), act_data, v.e_data);
      if (v.e_kinds[0]) checkOutput($sformatf("v%0d flags", i), 32'(act_flags), 32'(v.e_flags));
      checkOutput($sformatf("v%0d sp", i), 32'(v.inst_b ? sp_b : sp_a), 32'(v.e_sp));
      checkOutput($sformatf("v%0d depth", i), 32'(v.inst_b ? depth_b : depth_a), 32'(v.e_depth));
      checkOutput($sformatf("v%0d writes", i), 32'(rec_wr), 32'(v.e_wr));
      checkOutput($sformatf("v%0d reads", i), 32'(rec_rd), 32'(v.e_rd));
      checkOutput($sformatf("v%0d first addr", i), 32'(rec_addr0), 32'(v.e_addr0));
      checkOutput($sformatf("v%0d first wdata", i), 32'(rec_wdata0), 32'(v.e_wdata0));
      checkOutput($sformatf("v%0d overflow", i), 32'(v.inst_b ? overflow_b : overflow_a), 32'(v.e_ovf));
      checkOutput($sformatf("v%0d underflow", i), 32'(v.inst_b ? underflow_b : underflow_a), 32'(v.e_unf));
      checkOutput($sformatf("v%0d wr+rd overlap", i), 32'(rec_both), 32'd0);
    end

    // CALL memory image: high PC word deepest, then RET restores it.
    applyStimulus(1'b0, 3'd2, 16'h0, 32'h0001_0234, 4'h0);
    checkOutput("call mem[2047]", 32'(mem_a[2047]), 32'h0001);
    checkOutput("call mem[2046]", 32'(mem_a[2046]), 32'h0234);
    checkOutput("call sp", 32'(sp_a), 32'd2045);
    applyStimulus(1'b0, 3'd3, 16'h0, 32'h0, 4'h0);
    checkOutput("ret pulse cycle", 32'(rec_pulse), 32'd5);
    checkOutput("ret pc_out", pc_out_a, 32'h0001_0234);
    checkOutput("ret sp", 32'(sp_a), 32'd2047);

    // Reset in the middle of an INT, during its third write.
    @(negedge clk);
    req_op = 3'd4; pc_in = 32'h00AB_00CD; flags_in = 4'h5; req_valid_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("int 3rd write strobe", 32'(mem_wr_a), 32'd1);
    checkOutput("int sp before reset", 32'(sp_a), 32'd2045);
    rst = 1'b1;
    #1;
    checkOutput("mid-op reset sp", 32'(sp_a), 32'd2047);
    checkOutput("mid-op reset depth", 32'(depth_a), 32'd0);
    checkOutput("mid-op reset strobes", 32'({mem_wr_a, mem_rd_a, pop_valid_a, pc_load_a, flags_load_a}), 32'd0);
    @(negedge clk);
    checkOutput("partial write flags", 32'(mem_a[2047]), 32'h0005);
    checkOutput("partial write pc high", 32'(mem_a[2046]), 32'h00AB);
    checkOutput("no third write", 32'(mem_a[2045]), 32'h0050);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after release", 32'(req_ready_a), 32'd1);
    checkOutput("no pulses after release", 32'({pop_valid_a, pc_load_a, flags_load_a}), 32'd0);
    applyStimulus(1'b0, 3'd0, 16'h5A5A, 32'h0, 4'h0);
    checkOutput("post-reset push addr", 32'(rec_addr0), 32'd2047);
    checkOutput("post-reset push sp", 32'(sp_a), 32'd2046);
    applyStimulus(1'b0, 3'd1, 16'h0, 32'h0, 4'h0);
    checkOutput("post-reset pop data", 32'(pop_data_a), 32'h5A5A);
    checkOutput("post-reset pop depth", 32'(depth_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
